// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - parametrised show-ahead FIFO with fill level, almost-full, overwrite mode and sticky error flags
//
// Purpose: first-word-fall-through FIFO between a UART RX/TX path and the
// console mux arbiter. The oldest word sits in an output register and is
// presented on data_out while data_avail=1; adv pops it.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   w_en         write strobe, one word per cycle
//   adv          pop the word currently on data_out
//   data_in      write data
//   clear_flags  clears overflow/underflow
//   data_out     oldest word, valid while data_avail=1
//   data_avail   data_out holds a valid word
//   full         level == DEPTH
//   almost_full  level >= AFULL_THRESH
//   level        words written and not yet popped (output register included)
//   overflow     sticky: a write hit a full FIFO
//   underflow    sticky: adv while data_avail=0
module fifo_fwft #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = DEPTH - 4,
   parameter bit OVERWRITE    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic                     adv,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     clear_flags,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_avail,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF  = LW'(AFULL_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [LW-1:0]    ram_count;
   logic             pop_req;
   logic             force_pop;
   logic             pop_do;
   logic             wr_do;
   logic             load;

   assign full        = (level == LVL_MAX);
   assign almost_full = (level >= LVL_AF);

   // Words still in the RAM, i.e. not yet moved into the output register.
   assign ram_count = level - LW'(data_avail);

   assign pop_req   = adv & data_avail;
   // Overwrite mode: a write into a full FIFO behaves as an implicit pop of
   // the oldest word plus an append of the new one.
   assign force_pop = OVERWRITE & w_en & full & ~adv & data_avail;
   assign pop_do    = pop_req | force_pop;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts it.
   assign wr_do     = w_en & (~full | pop_do);
   // Refill the output register when it is empty or being vacated.
   assign load      = (~data_avail | pop_do) & (ram_count != '0);

   always_ff @(posedge clk) begin
      if (!rst && wr_do) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         data_out   <= '0;
         data_avail <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_do) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (load) begin
            data_out   <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
            data_avail <= 1'b1;
         end else if (pop_do) begin
            data_avail <= 1'b0;
         end

         level <= level + LW'(wr_do) - LW'(pop_do);

         // A new event wins over a coincident clear.
         if (w_en && full && !pop_req) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end

         if (adv && !data_avail) begin
            underflow <= 1'b1;
         end else if (clear_flags) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
